// File: rtl/intf_array_rr_arbiter.sv
// N-channel valid/ready arbiter merging an array of source channels into one
// registered output stream, with round-robin or fixed-priority grant and per-channel beat counters.
module intf_array_rr_arbiter #(
   parameter  int N     = 6,
   parameter  int W     = 8,
   parameter  int MODE  = 0,
   parameter  int CNT_W = 8,
   localparam int CHW   = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*W-1:0]     in_data,
   output logic [N-1:0]       in_ready,
   input  logic [N-1:0]       chan_en,
   output logic               out_valid,
   output logic [W-1:0]       out_data,
   output logic [CHW-1:0]     out_chan,
   input  logic               out_ready,
   output logic [N*CNT_W-1:0] cnt,
   input  logic               cnt_clr
);

   // Lowest set bit of a channel vector; returns 0 for an empty vector.
   function automatic logic [CHW-1:0] f_lowest(input logic [N-1:0] v);
      logic [CHW-1:0] r;
      r = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (v[k[CHW-1:0]]) begin
            r = CHW'(k);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   logic               r_out_valid;
   logic [W-1:0]       r_out_data;
   logic [CHW-1:0]     r_out_chan;
   logic [CHW-1:0]     r_last;
   logic [CNT_W-1:0]   r_cnt [N];

   logic [N-1:0]       w_elig;
   logic [N-1:0]       w_hi_mask;
   logic [N-1:0]       w_elig_hi;
   logic               w_any;
   logic               w_load;
   logic               w_xfer;
   logic [CHW-1:0]     w_grant;
   logic [W-1:0]       w_chan_data [N];
   logic [W-1:0]       w_sel_data;

   assign w_elig    = in_valid & chan_en;
   assign w_any     = |w_elig;
   assign w_load    = !r_out_valid || out_ready;
   assign w_xfer    = w_load && w_any;
   assign w_elig_hi = w_elig & w_hi_mask;

   // Channels strictly above the last winner get first look in round-robin.
   for (genvar k = 0; k < N; k++) begin : g_chan
      assign w_hi_mask[k]   = (CHW'(k) > r_last);
      assign w_chan_data[k] = in_data[k*W +: W];
      assign cnt[k*CNT_W +: CNT_W] = r_cnt[k];
   end

   // Grant selection: fixed priority, or wrap-around scan starting after r_last.
   always_comb begin
      w_grant = '0;
      if (MODE == 1) begin
         w_grant = f_lowest(w_elig);
      end else if (|w_elig_hi) begin
         w_grant = f_lowest(w_elig_hi);
      end else begin
         w_grant = f_lowest(w_elig);
      end
   end

   // Ready is one-hot on the winner and only while the output register can load.
   always_comb begin
      in_ready = '0;
      if (w_xfer) begin
         in_ready = {{(N-1){1'b0}}, 1'b1} << w_grant;
      end else begin
         in_ready = '0;
      end
   end

   // Only the granted channel's data reaches the output register.
   always_comb begin
      w_sel_data = '0;
      if (w_xfer) begin
         w_sel_data = w_chan_data[w_grant];
      end else begin
         w_sel_data = '0;
      end
   end

   // Output register: load winner, drop valid on an empty load, hold on stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_chan  <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_chan  <= w_grant;
      end else if (w_load) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

   // Round-robin pointer; reset to N-1 so channel 0 leads after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= CHW'(N - 1);
      end else if (w_xfer && (MODE == 0)) begin
         r_last <= w_grant;
      end else begin
         r_last <= r_last;
      end
   end

   // Per-channel accepted-beat counters; a clear beats a same-cycle increment.
   for (genvar k = 0; k < N; k++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt[k] <= '0;
         end else if (cnt_clr) begin
            r_cnt[k] <= '0;
         end else if (w_xfer && (w_grant == CHW'(k))) begin
            r_cnt[k] <= r_cnt[k] + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_cnt[k] <= r_cnt[k];
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_intf_array_rr_arbiter.sv
// Directed bench for intf_array_rr_arbiter: a round-robin and a fixed-priority
// instance share one stimulus stream; expected values are hand-computed.
module tb_intf_array_rr_arbiter;
   localparam int N = 6;
   localparam int W = 8;
   localparam int CNT_W = 8;
   localparam int CHW = 3;

   logic               clk;
   logic               rst;
   logic [N-1:0]       in_valid;
   logic [N*W-1:0]     in_data;
   logic [N-1:0]       chan_en;
   logic               out_ready;
   logic               cnt_clr;

   logic [N-1:0]       rr_in_ready,  fp_in_ready;
   logic               rr_out_valid, fp_out_valid;
   logic [W-1:0]       rr_out_data,  fp_out_data;
   logic [CHW-1:0]     rr_out_chan,  fp_out_chan;
   logic [N*CNT_W-1:0] rr_cnt,       fp_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   intf_array_rr_arbiter #(.N(N), .W(W), .MODE(0), .CNT_W(CNT_W)) u_rr (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rr_in_ready), .chan_en(chan_en), .out_valid(rr_out_valid),
      .out_data(rr_out_data), .out_chan(rr_out_chan), .out_ready(out_ready),
      .cnt(rr_cnt), .cnt_clr(cnt_clr)
   );

   intf_array_rr_arbiter #(.N(N), .W(W), .MODE(1), .CNT_W(CNT_W)) u_fp (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(fp_in_ready), .chan_en(chan_en), .out_valid(fp_out_valid),
      .out_data(fp_out_data), .out_chan(fp_out_chan), .out_ready(out_ready),
      .cnt(fp_cnt), .cnt_clr(cnt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] exp_seq [8];
      exp_seq = '{3'd5, 3'd0, 3'd2, 3'd3, 3'd5, 3'd0, 3'd2, 3'd3};

      rst = 1'b1; in_valid = 6'h00; in_data = 48'h0; chan_en = 6'h3F;
      out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (2) step();
      rst = 1'b0;

      // reset then idle
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq("idle_valid", 64'(rr_out_valid), 64'd0);
         check_eq("idle_chan",  64'(rr_out_chan),  64'd0);
         check_eq("idle_ready", 64'(rr_in_ready),  64'd0);
         check_eq("idle_cnt",   64'(rr_cnt),       64'd0);
      end

      // round-robin fairness
      in_data  = 48'h15_14_13_12_11_10;
      in_valid = 6'h3F;
      #1;
      check_eq("rr_first_ready", 64'(rr_in_ready), 64'h01);
      for (int i = 0; i < 12; i++) begin
         step();
         check_eq("rr_valid", 64'(rr_out_valid), 64'd1);
         check_eq("rr_chan",  64'(rr_out_chan),  64'(i % 6));
         check_eq("rr_data",  64'(rr_out_data),  64'(8'h10 + (i % 6)));
      end
      check_eq("rr_cnt12", 64'(rr_cnt), 64'h02_02_02_02_02_02);

      // backpressure with channel 2 on the output
      repeat (3) step();
      check_eq("bp_chan_pre", 64'(rr_out_chan), 64'd2);
      out_ready = 1'b0;
      #1;
      check_eq("bp_ready0", 64'(rr_in_ready), 64'h00);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("bp_valid", 64'(rr_out_valid), 64'd1);
         check_eq("bp_chan",  64'(rr_out_chan),  64'd2);
         check_eq("bp_data",  64'(rr_out_data),  64'h12);
         check_eq("bp_ready", 64'(rr_in_ready),  64'h00);
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp_resume_ready", 64'(rr_in_ready), 64'h08);
      step();
      check_eq("bp_resume_chan", 64'(rr_out_chan), 64'd3);
      check_eq("bp_resume_data", 64'(rr_out_data), 64'h13);
      check_eq("bp_cnt", 64'(rr_cnt), 64'h02_02_03_03_03_03);

      // clear counters during a stall
      out_ready = 1'b0;
      cnt_clr = 1'b1;
      step();
      check_eq("clr_cnt",  64'(rr_cnt),      64'd0);
      check_eq("clr_hold", 64'(rr_out_chan), 64'd3);
      cnt_clr = 1'b0;

      // mask and sparse grants, with a clear coincident with a channel-3 transfer
      chan_en = 6'h2D;
      out_ready = 1'b1;
      #1;
      check_eq("mask_ready", 64'(rr_in_ready), 64'h20);
      for (int i = 0; i < 8; i++) begin
         step();
         check_eq("mask_chan", 64'(rr_out_chan), 64'(exp_seq[i]));
         if (i == 6) begin
            check_eq("mask_cnt7", 64'(rr_cnt), 64'h02_00_01_02_00_02);
            cnt_clr = 1'b1;
            #1;
            check_eq("clr3_ready", 64'(rr_in_ready), 64'h08);
         end
      end
      check_eq("clr3_cnt_all", 64'(rr_cnt), 64'd0);
      check_eq("clr3_cnt3", 64'(rr_cnt[3*CNT_W +: CNT_W]), 64'd0);
      cnt_clr = 1'b0;
      chan_en = 6'h3F;

      // counter wrap on channel 0
      in_valid = 6'h01;
      #1;
      check_eq("wrap_ready", 64'(rr_in_ready), 64'h01);
      for (int i = 0; i < 256; i++) begin
         step();
         if (i == 254) check_eq("wrap_cnt255", 64'(rr_cnt[0 +: CNT_W]), 64'hFF);
      end
      check_eq("wrap_cnt0", 64'(rr_cnt), 64'd0);
      check_eq("wrap_chan", 64'(rr_out_chan), 64'd0);
      check_eq("wrap_data", 64'(rr_out_data), 64'h10);

      // fixed priority
      in_valid = 6'h24;
      #1;
      check_eq("fp_ready2", 64'(fp_in_ready), 64'h04);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("fp_chan2", 64'(fp_out_chan), 64'd2);
         check_eq("fp_data2", 64'(fp_out_data), 64'h12);
      end
      in_valid = 6'h20;
      #1;
      check_eq("fp_ready5", 64'(fp_in_ready), 64'h20);
      step();
      check_eq("fp_chan5", 64'(fp_out_chan), 64'd5);
      check_eq("fp_data5", 64'(fp_out_data), 64'h15);

      // async reset mid-stall
      in_valid = 6'h3F;
      out_ready = 1'b0;
      step();
      check_eq("ar_valid_pre", 64'(rr_out_valid), 64'd1);
      check_eq("ar_ready_pre", 64'(rr_in_ready), 64'h00);
      #2;
      rst = 1'b1;
      #1;
      check_eq("ar_valid",    64'(rr_out_valid), 64'd0);
      check_eq("ar_chan",     64'(rr_out_chan),  64'd0);
      check_eq("ar_data",     64'(rr_out_data),  64'd0);
      check_eq("ar_cnt",      64'(rr_cnt),       64'd0);
      check_eq("ar_fp_valid", 64'(fp_out_valid), 64'd0);
      in_valid = 6'h00;
      step();
      rst = 1'b0;
      step();
      check_eq("post_valid", 64'(rr_out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
